// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_pkg: shared AXI-lite widths, response codes, read FSM states |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2: two-input round-robin picker; a tie goes to the non-last one |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset value 1 makes master 0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      r_last_grant <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_rd_arb: 2-master to 1-slave AXI-lite read arbiter, one read  |
// | outstanding, registered slave address.   Revision: 1.0                |
// +----------------------------------------------------------------------+
module axi_lite_rd_arb
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr_q;
  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_gnt_rready;

  assign w_idle       = (r_state == RD_IDLE);
  assign w_gnt_rready = r_grant ? m1_rready : m0_rready;
  assign s_araddr     = r_addr_q;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_arvalid, m0_arvalid}),
    .advance (w_idle),
    .gnt     (w_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RD_IDLE;
      r_grant  <= 1'b0;
      r_addr_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && (w_gnt != 2'b00)) begin
        r_grant  <= w_gnt[1];
        r_addr_q <= w_gnt[1] ? m1_araddr : m0_araddr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m0_rresp    = RESP_OKAY;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
    m1_rresp    = RESP_OKAY;
    case (r_state)
      RD_IDLE: begin
        // Gated by rst so no handshake can be reported while held in reset.
        m0_arready = rst & w_gnt[0];
        m1_arready = rst & w_gnt[1];
        if (w_gnt != 2'b00) w_state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        s_rready = w_gnt_rready;
        if (r_grant) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && w_gnt_rready) w_state_nxt = RD_IDLE;
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_lite_rd_arb: scoreboard bench with slave model and ref FSM     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_axi_lite_rd_arb;
  import axi_lite_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, s_araddr;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [63:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;

  always #5 clk = ~clk;

  axi_lite_rd_arb #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m0_reqs[$];
  logic [31:0] m1_reqs[$];
  logic [31:0] ar_q[$];
  exp_t        r_q[$];

  int          mdl_st, mdl_last;
  int          ar_stall, ar_cnt, r_lat, r_cnt;
  logic        sl_busy, err_en;
  logic [31:0] sl_addr, err_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a ^ 32'h1234_5678, ~a};
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (err_en && a == err_addr) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  // Drives masters and slave model; called just after each rising edge.
  task automatic drive();
    m0_arvalid = (m0_reqs.size() > 0);
    m0_araddr  = 32'h0;
    if (m0_arvalid) m0_araddr = m0_reqs[0];
    m1_arvalid = (m1_reqs.size() > 0);
    m1_araddr  = 32'h0;
    if (m1_arvalid) m1_araddr = m1_reqs[0];
    s_arready = s_arvalid && !sl_busy && (ar_cnt >= ar_stall);
    s_rvalid  = sl_busy && (r_cnt >= r_lat);
    s_rdata   = s_rvalid ? data_of(sl_addr) : 64'h0;
    s_rresp   = s_rvalid ? resp_of(sl_addr) : RESP_OKAY;
  endtask

  // Reference model: checks outputs mid-cycle and advances on the coming edge.
  task automatic monitor();
    int          win;
    int          gid;
    logic        g_rready;
    logic [31:0] a;
    exp_t        e;
    win      = -1;
    gid      = (r_q.size() > 0) ? r_q[0].id : 0;
    g_rready = (gid == 1) ? m1_rready : m0_rready;
    if (mdl_st == 0) begin
      if (m0_arvalid && m1_arvalid) win = (mdl_last == 1) ? 0 : 1;
      else if (m0_arvalid)          win = 0;
      else if (m1_arvalid)          win = 1;
    end
    chk("m0_arready", 64'(m0_arready), 64'(win == 0));
    chk("m1_arready", 64'(m1_arready), 64'(win == 1));
    chk("s_arvalid",  64'(s_arvalid),  64'(mdl_st == 1));
    chk("s_rready",   64'(s_rready),   64'(mdl_st == 2 && g_rready));
    chk("m0_rvalid",  64'(m0_rvalid),  64'(mdl_st == 2 && gid == 0 && s_rvalid));
    chk("m1_rvalid",  64'(m1_rvalid),  64'(mdl_st == 2 && gid == 1 && s_rvalid));
    case (mdl_st)
      0: if (win >= 0) begin
        a = (win == 1) ? m1_reqs.pop_front() : m0_reqs.pop_front();
        ar_q.push_back(a);
        r_q.push_back('{win, a, data_of(a), resp_of(a)});
        mdl_last = win;
        mdl_st   = 1;
      end
      1: begin
        chk("s_araddr", 64'(s_araddr), 64'(ar_q[0]));
        if (s_arready) begin
          void'(ar_q.pop_front());
          sl_busy = 1'b1;
          sl_addr = s_araddr;
          ar_cnt  = 0;
          r_cnt   = 0;
          mdl_st  = 2;
        end else begin
          ar_cnt++;
        end
      end
      default: if (s_rvalid) begin
        e = r_q[0];
        chk("rdata", (gid == 1) ? m1_rdata : m0_rdata, e.data);
        chk("rresp", 64'((gid == 1) ? m1_rresp : m0_rresp), 64'(e.resp));
        chk("idle_rdata", (gid == 1) ? m0_rdata : m1_rdata, 64'h0);
        if (g_rready) begin
          void'(r_q.pop_front());
          sl_busy = 1'b0;
          mdl_st  = 0;
        end
      end else begin
        r_cnt++;
      end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((m0_reqs.size() > 0 || m1_reqs.size() > 0 || r_q.size() > 0 || mdl_st != 0)
           && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk("timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_rvalid(input int budget);
    int n;
    n = 0;
    while (!(mdl_st == 2 && s_rvalid) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk("rvalid_timeout", 64'(1), 64'(0));
  endtask

  task automatic model_reset();
    m0_reqs.delete();
    m1_reqs.delete();
    ar_q.delete();
    r_q.delete();
    mdl_st   = 0;
    mdl_last = 1;
    sl_busy  = 1'b0;
    sl_addr  = 32'h0;
    ar_cnt   = 0;
    r_cnt    = 0;
  endtask

  initial begin
    rst       = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    ar_stall  = 0;
    r_lat     = 1;
    err_en    = 1'b0;
    err_addr  = 32'h0;
    s_arready = 1'b0;
    model_reset();
    drive();
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    m0_araddr  = 32'hDEAD_0000;
    m1_araddr  = 32'hBEEF_0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_arready", 64'(m0_arready), 64'(0));
    chk("rst_m1_arready", 64'(m1_arready), 64'(0));
    chk("rst_s_arvalid",  64'(s_arvalid),  64'(0));
    chk("rst_s_araddr",   64'(s_araddr),   64'(0));
    chk("rst_s_rready",   64'(s_rready),   64'(0));
    drive();
    rst = 1'b1;

    // First tie after reset: m0 then m1.
    m0_reqs.push_back(32'h8000_0000);
    m1_reqs.push_back(32'h8000_1000);
    drive();
    run_until_done(100);

    // Single IFU read with the reference data word.
    m0_reqs.push_back(32'h8000_0000);
    drive();
    run_until_done(100);

    // Both masters kept busy: grants alternate.
    for (int i = 0; i < 4; i++) begin
      m0_reqs.push_back(32'h8000_2000 + 32'(i * 8));
      m1_reqs.push_back(32'h9000_2000 + 32'(i * 8));
    end
    drive();
    run_until_done(300);

    // Address backpressure, then LSU read-data backpressure.
    ar_stall  = 4;
    r_lat     = 2;
    m1_rready = 1'b0;
    m1_reqs.push_back(32'h8000_3000);
    drive();
    wait_rvalid(100);
    repeat (3) cycle();
    m1_rready = 1'b1;
    run_until_done(100);
    ar_stall = 0;
    r_lat    = 1;

    // Slave error passed through, then a normal read.
    err_en   = 1'b1;
    err_addr = 32'h0000_0000;
    m1_reqs.push_back(32'h0000_0000);
    drive();
    run_until_done(100);
    m0_reqs.push_back(32'h8000_4000);
    drive();
    run_until_done(100);
    err_en = 1'b0;

    // Asynchronous reset while data is being presented.
    m0_rready = 1'b0;
    m0_reqs.push_back(32'h8000_5000);
    drive();
    wait_rvalid(100);
    m0_rready = 1'b1;
    #1;
    chk("pre_rst_s_rready",  64'(s_rready),  64'(1));
    chk("pre_rst_m0_rvalid", 64'(m0_rvalid), 64'(1));
    #1;
    rst = 1'b0;
    #1;
    chk("arst_s_arvalid", 64'(s_arvalid), 64'(0));
    chk("arst_s_rready",  64'(s_rready),  64'(0));
    chk("arst_m0_rvalid", 64'(m0_rvalid), 64'(0));
    chk("arst_m1_rvalid", 64'(m1_rvalid), 64'(0));
    chk("arst_m0_rdata",  m0_rdata,       64'h0);
    chk("arst_s_araddr",  64'(s_araddr),  64'(0));
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m1_reqs.push_back(32'h8000_6000);
    m0_reqs.push_back(32'h8000_7000);
    drive();
    run_until_done(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
